// File: rtl/nd_2to1_pkg.sv
// rtl/nd_2to1_pkg.sv - shared constants, sender states and arbitration helper for the 2-to-1 merge
package nd_2to1_pkg;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam int NS_2TO1_FSZ     = 4;
  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;
  localparam int NS_REQ_CKS      = 2;
  localparam int NS_ACK_CKS      = 1;

  typedef enum logic [1:0] {
    SND_IDLE     = 2'd0,
    SND_REQ      = 2'd1,
    SND_WAIT_LOW = 2'd2
  } snd_state_t;

  // One-hot grant {ch1, ch0}; on contention the channel that did not win last time goes first.
  function automatic logic [1:0] nd_arb(input logic p0, input logic p1, input logic rr,
                                        input logic can);
    logic [1:0] g;
    g = 2'b00;
    if (can) begin
      if (p0 && p1) g = rr ? 2'b01 : 2'b10;
      else if (p0)  g = 2'b01;
      else if (p1)  g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/nd_2to1_debounce.sv
// rtl/nd_2to1_debounce.sv - level debouncer: a change is taken after CKS stable samples (CKS=0 passes through)
module nd_2to1_debounce #(
  parameter int CKS = 1
) (
  input  logic gch_clk,
  input  logic gch_reset,
  input  logic init,
  input  logic raw,
  output logic level,
  output logic ready
);

  localparam int CW = (CKS > 1) ? $clog2(CKS) : 1;

  logic          db;
  logic          rdy;
  logic [CW-1:0] cnt;

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      db  <= 1'b0;
      cnt <= '0;
      rdy <= 1'b0;
    end else if (init) begin
      db  <= 1'b0;
      cnt <= '0;
      rdy <= 1'b1;
    end else if (raw == db) begin
      cnt <= '0;
    end else if ((CKS <= 1) || (cnt == CW'(CKS - 1))) begin
      db  <= raw;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  if (CKS == 0) begin : g_pass
    assign level = raw;
  end else begin : g_reg
    assign level = db;
  end

  assign ready = rdy;

endmodule

// File: rtl/nd_msg_fifo.sv
// rtl/nd_msg_fifo.sv - message FIFO holding packed {dst,dat,red}; depth FSZ is a power of two
module nd_msg_fifo #(
  parameter int FSZ = 4,
  parameter int ASZ = 8,
  parameter int DSZ = 8,
  parameter int RSZ = 4,
  localparam int MW = ASZ + DSZ + RSZ
) (
  input  logic          gch_clk,
  input  logic          clr,
  input  logic          push,
  input  logic [MW-1:0] push_msg,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [MW-1:0] head
);

  localparam int IW = $clog2(FSZ);

  logic [MW-1:0] mem [FSZ];
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic [IW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (IW + 1)'(FSZ));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_idx];

  always_ff @(posedge gch_clk) begin
    if (clr) begin
      rd_idx <= '0;
      wr_idx <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= push_msg;
        wr_idx      <= wr_idx + IW'(1);
      end
      if (do_pop) rd_idx <= rd_idx + IW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (IW + 1)'(1);
        2'b01:   cnt <= cnt - (IW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nd_2to1.sv
// rtl/nd_2to1.sv - 2-to-1 merge stage: debounced 4-phase inputs, round-robin arbiter, FIFO, 4-phase sender
module nd_2to1
  import nd_2to1_pkg::*;
#(
  parameter int FSZ         = NS_2TO1_FSZ,
  parameter int ASZ         = NS_ADDRESS_SIZE,
  parameter int DSZ         = NS_DATA_SIZE,
  parameter int RSZ         = NS_REDUN_SIZE,
  parameter int RCV_REQ_CKS = NS_REQ_CKS,
  parameter int SND_ACK_CKS = NS_ACK_CKS
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_req,
  input  logic           snd0_ack,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [ASZ-1:0] rcv1_dst,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic [RSZ-1:0] rcv1_red,
  input  logic           rcv1_req,
  output logic           rcv1_ack
);

  localparam int MW = ASZ + DSZ + RSZ;

  logic          rdy;
  logic          init_cyc;
  snd_state_t    state;
  snd_state_t    state_nxt;
  logic          ack0;
  logic          ack1;
  logic          rr;
  logic          req0_db, req1_db, ack_db;
  logic          dbr0, dbr1, dbra;
  logic          fifo_clr, push, pop, full, empty, can_push;
  logic          pend0, pend1;
  logic [1:0]    grant;
  logic [MW-1:0] push_msg;
  logic [MW-1:0] head;

  assign init_cyc = ~rdy;

  nd_2to1_debounce #(.CKS(RCV_REQ_CKS)) u_db_rcv0 (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .init(init_cyc),
    .raw(rcv0_req), .level(req0_db), .ready(dbr0)
  );

  nd_2to1_debounce #(.CKS(RCV_REQ_CKS)) u_db_rcv1 (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .init(init_cyc),
    .raw(rcv1_req), .level(req1_db), .ready(dbr1)
  );

  nd_2to1_debounce #(.CKS(SND_ACK_CKS)) u_db_snd0 (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .init(init_cyc),
    .raw(snd0_ack), .level(ack_db), .ready(dbra)
  );

  assign pend0    = rdy & req0_db & ~ack0;
  assign pend1    = rdy & req1_db & ~ack1;
  assign pop      = rdy && (state == SND_IDLE) && !empty;
  assign can_push = !full || pop;
  assign grant    = nd_arb(pend0, pend1, rr, can_push);
  assign push     = grant[0] | grant[1];
  assign push_msg = grant[1] ? {rcv1_dst, rcv1_dat, rcv1_red} : {rcv0_dst, rcv0_dat, rcv0_red};
  assign fifo_clr = gch_reset | ~rdy;

  nd_msg_fifo #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_fifo (
    .gch_clk(gch_clk), .clr(fifo_clr), .push(push), .push_msg(push_msg),
    .pop(pop), .full(full), .empty(empty), .head(head)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      SND_IDLE:     if (pop) state_nxt = SND_REQ;
      SND_REQ:      if (ack_db) state_nxt = SND_WAIT_LOW;
      SND_WAIT_LOW: if (!ack_db) state_nxt = SND_IDLE;
      default:      state_nxt = SND_IDLE;
    endcase
  end

  // Reset and the init cycle clear the same state; only the init cycle raises rdy.
  always_ff @(posedge gch_clk) begin
    if (gch_reset || !rdy) begin
      rdy      <= gch_reset ? NS_OFF : NS_ON;
      state    <= SND_IDLE;
      ack0     <= NS_OFF;
      ack1     <= NS_OFF;
      rr       <= 1'b0;
      snd0_dst <= '0;
      snd0_dat <= '0;
      snd0_red <= '0;
    end else begin
      state <= state_nxt;
      if (pop) {snd0_dst, snd0_dat, snd0_red} <= head;
      if (grant[0])               ack0 <= NS_ON;
      else if (ack0 && !req0_db)  ack0 <= NS_OFF;
      if (grant[1])               ack1 <= NS_ON;
      else if (ack1 && !req1_db)  ack1 <= NS_OFF;
      if (push) rr <= grant[1];
    end
  end

  assign snd0_req  = (state == SND_REQ);
  assign rcv0_ack  = ack0;
  assign rcv1_ack  = ack1;
  assign gch_ready = rdy & dbr0 & dbr1 & dbra;

endmodule

// File: tb/tb_nd_2to1.sv
// tb/tb_nd_2to1.sv - self-checking bench for nd_2to1 with a transaction-level scoreboard
`timescale 1ns/1ps
module tb_nd_2to1;

  localparam int FSZ = 4, ASZ = 8, DSZ = 8, RSZ = 4;
  localparam int RCK = 2, ACK = 1;
  localparam int LAT_REQ = RCK + 2;

  typedef struct {
    int             ch;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_t;

  typedef struct {
    int             ch;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
    int             dly;
    int             exp_lat;
    logic [ASZ-1:0] exp_dst;
    logic [DSZ-1:0] exp_dat;
    logic [RSZ-1:0] exp_red;
  } vec_t;

  logic gch_clk = 1'b0, gch_reset = 1'b1, gch_ready;
  logic [ASZ-1:0] snd0_dst, rcv0_dst = '0, rcv1_dst = '0;
  logic [DSZ-1:0] snd0_dat, rcv0_dat = '0, rcv1_dat = '0;
  logic [RSZ-1:0] snd0_red, rcv0_red = '0, rcv1_red = '0;
  logic snd0_req, snd0_ack = 1'b0;
  logic rcv0_req = 1'b0, rcv0_ack, rcv1_req = 1'b0, rcv1_ack;

  int n_cmp = 0, n_err = 0;
  msg_t model_q[$];
  int out_ch[$], out_dat[$], ack_ch[$];
  msg_t cur[2];
  int n_acks[2];
  int n_deliv = 0;
  msg_t held;
  logic have_held = 1'b0;
  logic p_ack0 = 1'b0, p_ack1 = 1'b0, p_req = 1'b0;
  logic cons_en = 1'b1;
  int cons_dly = 0;

  nd_2to1 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .RCV_REQ_CKS(RCK), .SND_ACK_CKS(ACK)) dut (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(gch_ready),
    .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
    .snd0_req(snd0_req), .snd0_ack(snd0_ack),
    .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red),
    .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
    .rcv1_dst(rcv1_dst), .rcv1_dat(rcv1_dat), .rcv1_red(rcv1_red),
    .rcv1_req(rcv1_req), .rcv1_ack(rcv1_ack)
  );

  always #5 gch_clk = ~gch_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (got timeout, expected event)", nm);
  endtask

  // Scoreboard: an accepted message (ack rise) joins the expected queue; each snd0_req rise must carry its head.
  always begin
    @(negedge gch_clk);
    if (!gch_reset && gch_ready) begin
      if (rcv0_ack && !p_ack0 && rcv1_ack && !p_ack1) check("dual_ack_same_cycle", 1, 0);
      if (rcv0_ack && !p_ack0) begin model_q.push_back(cur[0]); ack_ch.push_back(0); n_acks[0]++; end
      if (rcv1_ack && !p_ack1) begin model_q.push_back(cur[1]); ack_ch.push_back(1); n_acks[1]++; end
      if (snd0_req && !p_req) begin
        check("deliver_expected", (model_q.size() != 0), 1);
        if (model_q.size() != 0) begin
          held = model_q.pop_front();
          have_held = 1'b1;
          check("snd0_fields", {snd0_dst, snd0_dat, snd0_red}, {held.dst, held.dat, held.red});
          out_ch.push_back(held.ch);
          out_dat.push_back(int'(held.dat));
          n_deliv++;
        end
      end
      if (!snd0_req && p_req && have_held)
        check("snd0_hold", {snd0_dst, snd0_dat, snd0_red}, {held.dst, held.dat, held.red});
    end
    p_ack0 = rcv0_ack;
    p_ack1 = rcv1_ack;
    p_req  = snd0_req;
  end

  // Consumer: acks cons_dly cycles after seeing req, drops ack once req falls.
  initial begin
    int dly_cnt;
    dly_cnt = 0;
    forever begin
      @(negedge gch_clk);
      if (!cons_en) begin
        snd0_ack = 1'b0;
        dly_cnt  = 0;
      end else if (snd0_req && !snd0_ack) begin
        if (dly_cnt >= cons_dly) begin snd0_ack = 1'b1; dly_cnt = 0; end
        else dly_cnt++;
      end else if (!snd0_req && snd0_ack) begin
        snd0_ack = 1'b0;
      end
    end
  end

  function automatic logic ack_of(input int ch);
    return (ch == 0) ? rcv0_ack : rcv1_ack;
  endfunction

  task automatic send(input int ch, input logic [ASZ-1:0] dst, input logic [DSZ-1:0] dat,
                      input logic [RSZ-1:0] red);
    int k;
    cur[ch] = '{ch: ch, dst: dst, dat: dat, red: red};
    if (ch == 0) begin rcv0_dst = dst; rcv0_dat = dat; rcv0_red = red; rcv0_req = 1'b1; end
    else         begin rcv1_dst = dst; rcv1_dat = dat; rcv1_red = red; rcv1_req = 1'b1; end
    for (k = 0; k < 1500; k++) begin @(negedge gch_clk); if (ack_of(ch)) break; end
    if (k >= 1500) timeout("send_ack_high");
    if (ch == 0) rcv0_req = 1'b0; else rcv1_req = 1'b0;
    for (k = 0; k < 200; k++) begin @(negedge gch_clk); if (!ack_of(ch)) break; end
    if (k >= 200) timeout("send_ack_low");
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge gch_clk);
      if (model_q.size() == 0 && !snd0_req && !snd0_ack && !rcv0_ack && !rcv1_ack) break;
    end
    if (k >= 3000) timeout("drain");
    repeat (6) @(negedge gch_clk);
  endtask

  initial begin
    vec_t vecs[5];
    int lat, b0, b1, bd, bo;
    logic done;

    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int lat, b0, bd, bo;
    logic done;

    vecs[0] = '{0, 8'd5,   8'hA5, 4'h3, 1, LAT_REQ, 8'd5,   8'hA5, 4'h3};
    vecs[1] = '{1, 8'd200, 8'h3C, 4'hF, 0, LAT_REQ, 8'd200, 8'h3C, 4'hF};
    vecs[2] = '{1, 8'd0,   8'hFF, 4'h0, 3, LAT_REQ, 8'd0,   8'hFF, 4'h0};
    vecs[3] = '{0, 8'hFF,  8'h00, 4'hA, 2, LAT_REQ, 8'hFF,  8'h00, 4'hA};
    vecs[4] = '{0, 8'h81,  8'h5A, 4'h5, 0, LAT_REQ, 8'h81,  8'h5A, 4'h5};

    // Reset and init
    repeat (3) @(negedge gch_clk);
    check("reset_ready", gch_ready, 0);
    check("reset_outs", {snd0_req, rcv0_ack, rcv1_ack, snd0_dst, snd0_dat, snd0_red}, 0);
    gch_reset = 1'b0;
    @(negedge gch_clk);
    check("init_ready", gch_ready, 1);
    check("init_outs", {snd0_req, rcv0_ack, rcv1_ack, snd0_dst, snd0_dat, snd0_red}, 0);

    // Single messages from the table: latency, fields, one ack each
    for (int i = 0; i < 5; i++) begin
      cons_dly = vecs[i].dly;
      b0 = n_acks[vecs[i].ch];
      lat = 0;
      fork
        send(vecs[i].ch, vecs[i].dst, vecs[i].dat, vecs[i].red);
        begin
          for (int k = 1; k <= 60; k++) begin
            @(negedge gch_clk);
            if (snd0_req) begin lat = k; break; end
          end
        end
      join
      check("vec_latency", lat, vecs[i].exp_lat);
      check("vec_fields", {snd0_dst, snd0_dat, snd0_red},
            {vecs[i].exp_dst, vecs[i].exp_dat, vecs[i].exp_red});
      wait_idle();
      check("vec_ack_once", n_acks[vecs[i].ch] - b0, 1);
    end

    // Simultaneous requests with rr=0: channel 1 first
    cons_dly = 1;
    bo = out_dat.size();
    b0 = ack_ch.size();
    fork
      send(0, 8'd1, 8'd1, 4'h1);
      send(1, 8'd2, 8'd2, 4'h2);
    join
    wait_idle();
    check("both_first_ack", ack_ch[b0], 1);
    check("both_second_ack", ack_ch[b0+1], 0);
    check("both_out0", out_dat[bo], 2);
    check("both_out1", out_dat[bo+1], 1);

    // Consumer stalled: sender register plus a full FIFO, sixth message back-pressured
    cons_en = 1'b0;
    b0 = n_acks[0];
    bo = out_dat.size();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, 8'(i), 8'(8'h10 + i), 4'(i));
        done = 1'b1;
      end
    join_none
    repeat (150) @(negedge gch_clk);
    check("stall_acks", n_acks[0] - b0, 1 + FSZ);
    check("stall_6th_unacked", rcv0_ack, 0);
    check("stall_snd_req", snd0_req, 1);
    cons_en = 1'b1;
    for (int k = 0; k < 2000 && !done; k++) @(negedge gch_clk);
    if (!done) timeout("stall_sender_done");
    wait_idle();
    check("stall_deliv_cnt", out_dat.size() - bo, 6);
    for (int i = 0; i < 6; i++) check("stall_order", out_dat[bo+i], 8'h10 + i);

    // Both inputs streaming in lockstep: strict alternation starting with channel 1
    cons_dly = 0;
    bd = n_deliv;
    bo = out_ch.size();
    fork
      for (int i = 0; i < 8; i++) send(0, 8'h30, 8'(8'h20 + i), 4'h0);
      for (int i = 0; i < 8; i++) send(1, 8'h31, 8'(8'h40 + i), 4'h1);
    join
    wait_idle();
    check("stream_count", n_deliv - bd, 16);
    for (int j = 0; j < 16; j++) check("stream_alternate", out_ch[bo+j], (j % 2 == 0) ? 1 : 0);

    // Glitch shorter than RCV_REQ_CKS is ignored
    b0 = n_acks[0];
    bd = n_deliv;
    cur[0] = '{ch: 0, dst: 8'h66, dat: 8'h66, red: 4'h6};
    rcv0_dst = 8'h66; rcv0_dat = 8'h66; rcv0_red = 4'h6;
    rcv0_req = 1'b1;
    repeat (RCK - 1) @(negedge gch_clk);
    rcv0_req = 1'b0;
    repeat (20) @(negedge gch_clk);
    check("glitch_no_ack", n_acks[0] - b0, 0);
    check("glitch_no_deliv", n_deliv - bd, 0);

    // A pulse exactly RCV_REQ_CKS long is accepted
    cur[0] = '{ch: 0, dst: 8'h67, dat: 8'h67, red: 4'h7};
    rcv0_dst = 8'h67; rcv0_dat = 8'h67; rcv0_red = 4'h7;
    rcv0_req = 1'b1;
    repeat (RCK) @(negedge gch_clk);
    rcv0_req = 1'b0;
    wait_idle();
    check("pulse_eq_ack", n_acks[0] - b0, 1);
    check("pulse_eq_deliv", n_deliv - bd, 1);

    // Randomized traffic on both inputs with varying consumer delay
    for (int batch = 0; batch < 3; batch++) begin
      cons_dly = $urandom_range(0, 4);
      bd = n_deliv;
      fork
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(0, 6)) @(negedge gch_clk);
          send(0, 8'($urandom), 8'($urandom), 4'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(0, 6)) @(negedge gch_clk);
          send(1, 8'($urandom), 8'($urandom), 4'($urandom));
        end
      join
      wait_idle();
      check("rand_count", n_deliv - bd, 16);
      check("rand_model_empty", model_q.size(), 0);
    end

    // Reset with two messages queued and snd0_req high
    cons_en = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send(0, 8'h50, 8'(8'h50 + i), 4'h5);
        done = 1'b1;
      end
    join_none
    for (int k = 0; k < 500 && !done; k++) @(negedge gch_clk);
    if (!done) timeout("reset_prep");
    check("pre_reset_req", snd0_req, 1);
    gch_reset = 1'b1;
    @(negedge gch_clk);
    check("midrst_outs", {snd0_req, rcv0_ack, rcv1_ack, snd0_dst, snd0_dat, snd0_red}, 0);
    check("midrst_ready", gch_ready, 0);
    model_q.delete();
    have_held = 1'b0;
    @(negedge gch_clk);
    gch_reset = 1'b0;
    cons_en = 1'b1;
    @(negedge gch_clk);
    check("post_rst_ready", gch_ready, 1);
    bd = n_deliv;
    repeat (30) @(negedge gch_clk);
    check("post_rst_empty", n_deliv - bd, 0);
    check("post_rst_req", snd0_req, 0);
    send(1, 8'h77, 8'h77, 4'h7);
    wait_idle();
    check("post_rst_one", n_deliv - bd, 1);
    check("post_rst_dat", out_dat[out_dat.size()-1], 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
